// File: rtl/skew_delay_line.sv
// skew_delay_line
//   Multi-lane staggered delay line in front of (skew) or behind (deskew) the
//   NDP systolic array. Lane k delays its word by BASE_DELAY+k cycles in skew
//   mode and by BASE_DELAY+LANES-1-k cycles in deskew mode. Invalid slots
//   carry zeros so the array sees clean bubbles.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   en         advance enable (0 = stall, everything holds)
//   clear      synchronous flush of all data/valid stages (beats en)
//   mode       requested mode, 0 = skew, 1 = deskew (applied only while idle)
//   in_valid   input word group valid
//   in_data    LANES words, lane k at [k*WIDTH +: WIDTH]
//   out_valid  per-lane output valid
//   out_data   per-lane delayed data, same packing as in_data
//   busy       any valid bit in flight in any stage
//   mode_q     mode currently applied
//   beat_cnt   lane-0 output beat counter (only with SKEW_DELAY_LINE_CNT_EN)
//
// Build option: define SKEW_DELAY_LINE_CNT_EN to add the beat_cnt port.

module skew_delay_line #(
  parameter int LANES      = 4,
  parameter int WIDTH      = 8,
  parameter int BASE_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy,
  output logic                   mode_q
`ifdef SKEW_DELAY_LINE_CNT_EN
  ,
  output logic [31:0]            beat_cnt
`endif
);

  localparam int MAX_DELAY = BASE_DELAY + LANES - 1;

  logic [WIDTH-1:0]     data_q  [LANES][MAX_DELAY];
  logic [WIDTH-1:0]     data_d  [LANES][MAX_DELAY];
  logic [MAX_DELAY-1:0] valid_q [LANES];
  logic [MAX_DELAY-1:0] valid_d [LANES];
  logic                 mode_d;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      busy = busy | (|valid_q[k]);
    end
  end

  always_comb begin
    // Mode only follows the request while nothing is in flight, so a word
    // never changes its delay mid-way through the line.
    mode_d = mode_q;
    if (!busy && !clear) begin
      mode_d = mode;
    end

    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_d[k][i] = data_q[k][i];
      end
      valid_d[k] = valid_q[k];
    end

    if (clear) begin
      for (int k = 0; k < LANES; k++) begin
        for (int i = 0; i < MAX_DELAY; i++) begin
          data_d[k][i] = '0;
        end
        valid_d[k] = '0;
      end
    end else if (en) begin
      for (int k = 0; k < LANES; k++) begin
        // Bubbles must be zero: the array accumulates whatever it is fed.
        data_d[k][0]  = in_valid ? in_data[k*WIDTH +: WIDTH] : '0;
        valid_d[k][0] = in_valid;
        for (int i = 1; i < MAX_DELAY; i++) begin
          data_d[k][i]  = data_q[k][i-1];
          valid_d[k][i] = valid_q[k][i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LANES; k++) begin
        for (int i = 0; i < MAX_DELAY; i++) begin
          data_q[k][i] <= '0;
        end
        valid_q[k] <= '0;
      end
      mode_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  // Output tap of lane k is stage D_k-1; both candidate taps are fixed per
  // lane, so the mux is a 2:1 on mode_q behind registers.
  for (genvar k = 0; k < LANES; k++) begin : g_tap
    localparam int SKEW_TAP   = BASE_DELAY - 1 + k;
    localparam int DESKEW_TAP = MAX_DELAY - 1 - k;
    assign out_valid[k] = mode_q ? valid_q[k][DESKEW_TAP] : valid_q[k][SKEW_TAP];
    assign out_data[k*WIDTH +: WIDTH] = mode_q ? data_q[k][DESKEW_TAP] : data_q[k][SKEW_TAP];
  end

`ifdef SKEW_DELAY_LINE_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (en && out_valid[0]) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_skew_delay_line.sv
module tb_skew_delay_line;

  localparam int LANES = 4;
  localparam int WIDTH = 8;

  localparam int K_RST   = 0;
  localparam int K_CLR   = 1;
  localparam int K_ADV   = 2;
  localparam int K_STALL = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   en;
  logic                   clear;
  logic                   mode;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   busy;
  logic                   mode_q;
`ifdef SKEW_DELAY_LINE_CNT_EN
  logic [31:0]            beat_cnt;
`endif

  skew_delay_line #(.LANES(LANES), .WIDTH(WIDTH), .BASE_DELAY(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .mode_q    (mode_q)
`ifdef SKEW_DELAY_LINE_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic [7:0] data;
    int         edge_idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   en_cnt = 0;
  int   last_kind = K_RST;
  logic [LANES-1:0]       prev_valid = '0;
  logic [LANES*WIDTH-1:0] prev_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Count of advancing edges; arrivals are expressed in this time base so
  // stalled cycles drop out automatically.
  always @(posedge clk) begin
    if (!reset_n)      last_kind <= K_RST;
    else if (clear)    last_kind <= K_CLR;
    else if (en)       last_kind <= K_ADV;
    else               last_kind <= K_STALL;
    if (reset_n && en && !clear) en_cnt <= en_cnt + 1;
  end

  // Monitor: pops the expected word for each lane presenting valid data.
  always @(negedge clk) begin
    if (last_kind == K_ADV) begin
      for (int k = 0; k < LANES; k++) begin
        if (out_valid[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].lane == k) idx = i;
          end
          if (idx < 0) begin
            chk($sformatf("unexpected_lane%0d", k), 64'(out_data[k*WIDTH +: WIDTH]), 64'hDEAD_0000);
          end else begin
            chk($sformatf("data_lane%0d", k), 64'(out_data[k*WIDTH +: WIDTH]), 64'(exp_q[idx].data));
            chk($sformatf("arrival_lane%0d", k), 64'(en_cnt), 64'(exp_q[idx].edge_idx));
            exp_q.delete(idx);
          end
        end else begin
          chk($sformatf("pad_lane%0d", k), 64'(out_data[k*WIDTH +: WIDTH]), 64'd0);
        end
      end
    end else if (last_kind == K_STALL) begin
      chk("stall_hold_valid", 64'(out_valid), 64'(prev_valid));
      chk("stall_hold_data", 64'(out_data), 64'(prev_data));
    end
    prev_valid = out_valid;
    prev_data  = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dly(input logic m, input int k);
    return m ? (LANES - k) : (1 + k);
  endfunction

  // Drive one word group and queue its per-lane expectations. The capture
  // edge is the next one (en must be 1); lane k shows up D_k-1 edges later.
  task automatic send(input logic [31:0] w, input logic m);
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < LANES; k++) begin
      exp_t e;
      e.lane     = k;
      e.data     = w[k*8 +: 8];
      e.edge_idx = en_cnt + dly(m, k);
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mode_q", 64'(mode_q), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    idle(2);

    // Skew: lane k arrives k edges after lane 0.
    send(32'h44332211, 1'b0);
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) begin
      chk("skew_busy_in_flight", 64'(busy), 64'd1);
      tick();
    end
    chk("skew_busy_drained", 64'(busy), 64'd0);
    chk("skew_mode_q", 64'(mode_q), 64'd0);
    idle(1);
    chk("skew_drain", 64'(exp_q.size()), 64'd0);

    // Mode request while busy is ignored until the line empties.
    send(32'hA1B2C3D4, 1'b0);
    in_valid = 1'b0; in_data = '0; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("modechg_mode_q_held", 64'(mode_q), 64'd0);
      tick();
    end
    chk("modechg_idle", 64'(busy), 64'd0);
    chk("modechg_mode_q_before", 64'(mode_q), 64'd0);
    // Same-edge idle capture: new mode applies to this word.
    send(32'h55667788, 1'b1);
    chk("modechg_mode_q_after", 64'(mode_q), 64'd1);
    idle(5);
    chk("modechg_drain", 64'(exp_q.size()), 64'd0);

    // Deskew: lane 3 first, lane 0 last.
    send(32'h44332211, 1'b1);
    idle(5);
    chk("deskew_mode_q", 64'(mode_q), 64'd1);
    chk("deskew_drain", 64'(exp_q.size()), 64'd0);

    // Back to skew while idle, then a 4-word burst with a 2-cycle stall.
    mode = 1'b0;
    tick();
    chk("stall_mode_q", 64'(mode_q), 64'd0);
    send(32'h0F0E0D0C, 1'b0);
    send(32'h1F1E1D1C, 1'b0);
    send(32'h2F2E2D2C, 1'b0);
    send(32'h3F3E3D3C, 1'b0);
    in_valid = 1'b0; in_data = 32'hFFFFFFFF;
    en = 1'b0;
    tick();
    chk("stall_busy", 64'(busy), 64'd1);
    tick();
    en = 1'b1;
    idle(6);
    chk("stall_drain", 64'(exp_q.size()), 64'd0);

    // Clear with a new input on the same edge: everything dropped.
    send(32'h01020304, 1'b0);
    send(32'h05060708, 1'b0);
    send(32'h090A0B0C, 1'b0);
    in_valid = 1'b1; in_data = 32'hDEADBEEF; clear = 1'b1;
    tick();
    exp_q.delete();
    chk("clear_out_valid", 64'(out_valid), 64'd0);
    chk("clear_out_data", 64'(out_data), 64'd0);
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_mode_q", 64'(mode_q), 64'd0);
`ifdef SKEW_DELAY_LINE_CNT_EN
    chk("clear_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    clear = 1'b0;
    idle(5);
    chk("clear_quiet_busy", 64'(busy), 64'd0);
    chk("clear_quiet_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with words in flight.
    send(32'h11223344, 1'b0);
    send(32'h55667788, 1'b0);
    send(32'h99AABBCC, 1'b0);
    in_valid = 1'b0; in_data = '0;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_out_valid", 64'(out_valid), 64'd0);
      chk("postrst_busy", 64'(busy), 64'd0);
    end
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
